// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV64M integer divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int DIV_ITER_D = 64;
    localparam int DIV_ITER_W = 32;

    function automatic logic op_is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract divisor.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so the shifted value needs one extra bit; diff[WIDTH] is the borrow.
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (diff[WIDTH]) begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/int_divider.sv
// Iterative RV64M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Define RV64_DIVW_EN to add the `word` port for the 32-bit W variants (WIDTH must be 64).
module int_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_ITER_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
`ifdef RV64_DIVW_EN
    input  logic             word,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q;
    div_op_e          op_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
    logic [CNT_W-1:0] cnt_q, last_q;
    logic             quo_neg_q, rem_neg_q, busy_q, done_q;
`ifdef RV64_DIVW_EN
    logic             word_q;
`endif

    logic             sgn, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, quo_init, min_val;
    logic [CNT_W-1:0] last_d;
    logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix, result_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sgn     = op_is_signed(div_op_e'(op));
        a_ext   = dividend;
        b_ext   = divisor;
        min_val = {1'b1, {(WIDTH-1){1'b0}}};
        last_d  = CNT_W'(WIDTH - 1);
`ifdef RV64_DIVW_EN
        if (word) begin
            a_ext   = {{(WIDTH-32){sgn & dividend[31]}}, dividend[31:0]};
            b_ext   = {{(WIDTH-32){sgn & divisor[31]}}, divisor[31:0]};
            min_val = {{(WIDTH-31){1'b1}}, 31'b0};
            last_d  = CNT_W'(DIV_ITER_W - 1);
        end
`endif
        a_neg    = sgn & a_ext[WIDTH-1];
        b_neg    = sgn & b_ext[WIDTH-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = sgn && (a_ext == min_val) && (b_ext == '1);
        quo_init = a_mag;
`ifdef RV64_DIVW_EN
        // Word mode parks the 32-bit magnitude in the top half so 32 shifts consume it.
        if (word) quo_init = a_mag << DIV_ITER_W;
`endif
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    always_comb begin
        quo_fix  = quo_neg_q ? -quo_q : quo_q;
        rem_fix  = rem_neg_q ? -rem_q : rem_q;
        result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
`ifdef RV64_DIVW_EN
        if (word_q) result_d = {{(WIDTH-32){result_d[31]}}, result_d[31:0]};
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RV64_DIVW_EN
            word_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        op_q   <= div_op_e'(op);
                        cnt_q  <= '0;
                        last_q <= last_d;
                        busy_q <= 1'b1;
`ifdef RV64_DIVW_EN
                        word_q <= word;
`endif
                        // Fast paths preload final values with signs cleared; FIX passes them through.
                        if (div_zero) begin
                            quo_q     <= '1;
                            rem_q     <= a_ext;
                            quo_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIX;
                        end else if (ovf) begin
                            quo_q     <= a_ext;
                            rem_q     <= '0;
                            quo_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIX;
                        end else begin
                            quo_q     <= quo_init;
                            rem_q     <= '0;
                            dvs_q     <= b_mag;
                            quo_neg_q <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_q) state_q <= FIX;
                end
                FIX: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
